act_stream_arbiter: RTL and testbench

//  Shares one ReLU activation datapath among NUM_REQ producer streams (e.g. per-channel conv outputs).

---
 rtl/npu_act_pkg.sv | 25 ++
 rtl/act_relu_unit.sv | 19 +
 rtl/act_stream_arbiter.sv | 115 +++++++++++
 tb/tb_act_stream_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_act_pkg.sv
// Shared NPU activation types and the activation function.
// Holds ACT_DATA_W, act_data_t and act_apply(); imported by the act blocks.
package npu_act_pkg;

    localparam int ACT_DATA_W = 22;

    typedef logic signed [ACT_DATA_W-1:0] act_data_t;

    // Non-negative values pass; negatives either clamp to zero or take
    // an arithmetic right shift (rounds toward -inf, so -1 stays -1).
    function automatic act_data_t act_apply(
        input act_data_t   x,
        input logic        leaky,
        input int unsigned shift
    );
        if (!x[ACT_DATA_W-1]) begin
            return x;
        end else if (leaky) begin
            return x >>> shift;
        end else begin
            return '0;
        end
    endfunction

endpackage

// File: rtl/act_relu_unit.sv
// Combinational activation between pipeline stage 1 and stage 2.
// Ports: x_i (signed pixel in), y_o (activated pixel out).
// Macro ACT_LEAKY_RELU_EN selects leaky ReLU; default is plain ReLU.
module act_relu_unit
    import npu_act_pkg::*;
#(
    parameter int unsigned LEAKY_SHIFT = 3
) (
    input  act_data_t x_i,
    output act_data_t y_o
);

`ifdef ACT_LEAKY_RELU_EN
    assign y_o = act_apply(x_i, 1'b1, LEAKY_SHIFT);
`else
    assign y_o = act_apply(x_i, 1'b0, LEAKY_SHIFT);
`endif

endmodule

// File: rtl/act_stream_arbiter.sv
// Round-robin arbiter sharing one 2-stage ReLU pipeline among NUM_REQ streams.
// Ports: clk, rst (sync, active-high), req_valid/req_data/req_ready per
// requester, res_valid/res_data/res_id/res_ready result handshake, busy.
// Macro ACT_LEAKY_RELU_EN (in act_relu_unit) enables leaky ReLU.
module act_stream_arbiter
    import npu_act_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = ACT_DATA_W,
    parameter int LEAKY_SHIFT = 3,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           res_valid,
    output logic [DATA_W-1:0]              res_data,
    output logic [ID_W-1:0]                res_id,
    input  logic                           res_ready,
    output logic                           busy
);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]  s1_data_q, s1_data_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic               s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]  s2_data_q, s2_data_d;
    logic [ID_W-1:0]    s2_id_q, s2_id_d;

    logic               adv;
    logic               found;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    sel;
    logic               accept;
    logic [DATA_W-1:0]  act_y;

    assign adv = !s2_valid_q || res_ready;

    // Search from ptr+1 upward with wrap; first valid requester wins.
    always_comb begin
        found    = 1'b0;
        grant    = '0;
        grant_id = '0;
        sel      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sel = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[sel]) begin
                found       = 1'b1;
                grant[sel]  = 1'b1;
                grant_id    = sel;
            end
        end
    end

    assign req_ready = grant & {NUM_REQ{adv && !rst}};
    assign accept    = found && adv && !rst;

    act_relu_unit #(
        .LEAKY_SHIFT (LEAKY_SHIFT)
    ) u_relu (
        .x_i (s1_data_q),
        .y_o (act_y)
    );

    always_comb begin
        ptr_d      = ptr_q;
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        if (adv) begin
            s1_valid_d = accept;
            s2_valid_d = s1_valid_q;
            s2_data_d  = act_y;
            s2_id_d    = s1_id_q;
            if (accept) begin
                s1_data_d = req_data[grant_id];
                s1_id_d   = grant_id;
                ptr_d     = grant_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= ID_W'(NUM_REQ - 1);
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
        end
    end

    assign res_valid = s2_valid_q;
    assign res_data  = s2_data_q;
    assign res_id    = s2_id_q;
    assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_act_stream_arbiter.sv
// Directed self-checking bench for act_stream_arbiter.
// Define ACT_LEAKY_RELU_EN for both bench and RTL to check the leaky build.
module tb_act_stream_arbiter;

    logic             clk;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0][21:0] req_data;
    logic [3:0]       req_ready;
    logic             res_valid;
    logic [21:0]      res_data;
    logic [1:0]       res_id;
    logic             res_ready;
    logic             busy;

    int pass_cnt = 0;
    int total    = 0;

`ifdef ACT_LEAKY_RELU_EN
    localparam logic [21:0] NEG5_EXP = 22'h3FFFFF;
    localparam logic [21:0] MIN_EXP  = 22'h3C0000;
`else
    localparam logic [21:0] NEG5_EXP = 22'h000000;
    localparam logic [21:0] MIN_EXP  = 22'h000000;
`endif

    act_stream_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        req_data  = '0;
        res_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        total++;
        if (req_ready !== 4'b0000)
            $display("FAIL reset_ready got %b want 0000", req_ready);
        else pass_cnt++;
        total++;
        if ({res_valid, busy, res_data, res_id} !== 26'd0)
            $display("FAIL reset_out got v=%b b=%b d=%h id=%0d want zeros",
                     res_valid, busy, res_data, res_id);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0001)
            $display("FAIL reset_first_grant got %b want 0001", req_ready);
        else pass_cnt++;
        req_valid = '0;
    endtask

    task automatic test_relu_single();
        do_reset();
        res_ready   = 1'b1;
        req_valid   = 4'b0001;
        req_data[0] = 22'd100;
        #1;
        step();
        req_data[0] = -22'sd5;
        step();
        req_valid = '0;
        total++;
        if (!res_valid || res_data !== 22'd100 || res_id !== 2'd0)
            $display("FAIL relu_pos got v=%b d=%h id=%0d want 1 000064 0",
                     res_valid, res_data, res_id);
        else pass_cnt++;
        step();
        total++;
        if (!res_valid || res_data !== NEG5_EXP || res_id !== 2'd0)
            $display("FAIL relu_neg got v=%b d=%h id=%0d want 1 %h 0",
                     res_valid, res_data, res_id, NEG5_EXP);
        else pass_cnt++;
        step();
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL relu_drain got v=%b busy=%b want 0 0",
                     res_valid, busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i] = 22'((i + 1) * 1000);
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                total++;
                if (req_ready !== 4'(1 << (k % 4)))
                    $display("FAIL b2b_grant k=%0d got %b want %b",
                             k, req_ready, 4'(1 << (k % 4)));
                else pass_cnt++;
            end else begin
                req_valid = '0;
            end
            step();
            if (k >= 1) begin
                total++;
                if (!res_valid || res_id !== 2'((k - 1) % 4) ||
                    res_data !== 22'(((k - 1) % 4 + 1) * 1000))
                    $display("FAIL b2b_res k=%0d got v=%b id=%0d d=%0d want id=%0d",
                             k, res_valid, res_id, res_data, (k - 1) % 4);
                else pass_cnt++;
            end
        end
        step();
        step();
    endtask

    task automatic test_stall();
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i] = 22'((i + 1) * 1000);
        req_valid = 4'b1111;
        step();
        step();
        step();
        res_ready = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (req_ready !== 4'b0000 || !res_valid || res_id !== 2'd1 ||
                res_data !== 22'd2000 || !busy)
                $display("FAIL stall_hold c=%0d got rdy=%b v=%b id=%0d d=%0d want 0000 1 1 2000",
                         c, req_ready, res_valid, res_id, res_data);
            else pass_cnt++;
            step();
        end
        res_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b1000)
            $display("FAIL stall_resume_grant got %b want 1000", req_ready);
        else pass_cnt++;
        for (int j = 0; j < 4; j++) begin
            if (j == 3) req_valid = '0;
            step();
            total++;
            if (!res_valid || res_id !== 2'((2 + j) % 4) ||
                res_data !== 22'(((2 + j) % 4 + 1) * 1000))
                $display("FAIL stall_order j=%0d got v=%b id=%0d want id=%0d",
                         j, res_valid, res_id, (2 + j) % 4);
            else pass_cnt++;
        end
        step();
        step();
    endtask

    task automatic test_pointer();
        do_reset();
        res_ready   = 1'b1;
        req_data[1] = 22'd11;
        req_data[3] = 22'd33;
        req_valid   = 4'b0010;
        step();
        req_valid = '0;
        step();
        step();
        step();
        req_valid = 4'b1010;
        #1;
        total++;
        if (req_ready !== 4'b1000)
            $display("FAIL ptr_grant3 got %b want 1000", req_ready);
        else pass_cnt++;
        step();
        req_valid = 4'b0010;
        #1;
        total++;
        if (req_ready !== 4'b0010)
            $display("FAIL ptr_grant1 got %b want 0010", req_ready);
        else pass_cnt++;
        step();
        req_valid = '0;
        total++;
        if (!res_valid || res_id !== 2'd3 || res_data !== 22'd33)
            $display("FAIL ptr_res3 got v=%b id=%0d d=%0d want 1 3 33",
                     res_valid, res_id, res_data);
        else pass_cnt++;
        step();
        total++;
        if (!res_valid || res_id !== 2'd1 || res_data !== 22'd11)
            $display("FAIL ptr_res1 got v=%b id=%0d d=%0d want 1 1 11",
                     res_valid, res_id, res_data);
        else pass_cnt++;
        step();
    endtask

    task automatic test_midreset();
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i] = 22'(i + 5);
        req_valid = 4'b1111;
        step();
        step();
        total++;
        if (busy !== 1'b1 || res_valid !== 1'b1)
            $display("FAIL midrst_full got busy=%b v=%b want 1 1", busy, res_valid);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0000)
            $display("FAIL midrst_ready got %b want 0000", req_ready);
        else pass_cnt++;
        step();
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL midrst_flush got v=%b busy=%b want 0 0", res_valid, busy);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0001)
            $display("FAIL midrst_grant got %b want 0001", req_ready);
        else pass_cnt++;
        req_valid = '0;
        step();
    endtask

    task automatic test_boundary();
        do_reset();
        res_ready   = 1'b1;
        req_valid   = 4'b0001;
        req_data[0] = 22'h1FFFFF;
        step();
        req_data[0] = 22'h200000;
        step();
        req_valid = '0;
        total++;
        if (!res_valid || res_data !== 22'h1FFFFF)
            $display("FAIL bnd_max got v=%b d=%h want 1 1fffff", res_valid, res_data);
        else pass_cnt++;
        step();
        total++;
        if (!res_valid || res_data !== MIN_EXP)
            $display("FAIL bnd_min got v=%b d=%h want 1 %h", res_valid, res_data, MIN_EXP);
        else pass_cnt++;
        step();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b1;
        test_reset();
        test_relu_single();
        test_back_to_back();
        test_stall();
        test_pointer();
        test_midreset();
        test_boundary();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
